// File: rtl/fp16_pkg.sv
// Shared FP16 normalization types, widths and the leading-one search helper.
package fp16_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_MANT_W = 11;
  localparam int FP16_REQ_W  = 1 + FP16_EXP_W + FP16_MANT_W;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_unnorm_t;

  // Position of the most significant set bit of the explicit fraction bits (0 if none).
  function automatic logic [3:0] lead_one_idx(input logic [FP16_FRAC_W-1:0] m);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 0; i < FP16_FRAC_W; i++) begin
      pos = m[i] ? 4'(i) : pos;
    end
    return pos;
  endfunction

endpackage

// File: rtl/fp16_norm_core.sv
// Combinational second-stage normalizer: left shift and exponent decrement,
// clamping to the subnormal range when the exponent would run out.
module fp16_norm_core
  import fp16_pkg::*;
(
  input  logic [FP16_EXP_W-1:0]  exp,
  input  logic [FP16_MANT_W-1:0] mant,
  input  logic [3:0]             idx,
  input  logic                   nz,
  output logic [FP16_EXP_W-1:0]  norm_exp,
  output logic [FP16_FRAC_W-1:0] norm_frac
);

  logic [5:0]             lz_s;
  logic [5:0]             exp_ext_s;
  logic [FP16_MANT_W-1:0] shl_lz_s;
  logic [FP16_MANT_W-1:0] shl_sub_s;

  assign lz_s      = 6'd10 - {2'b00, idx};
  assign exp_ext_s = {1'b0, exp};
  assign shl_lz_s  = mant << lz_s;
  // Only consumed when exp >= 1, so the decrement never wraps where it matters.
  assign shl_sub_s = mant << (exp - 5'd1);

  // Select the normalization case from hidden bit, zero, subnormal and exponent range.
  always_comb begin
    norm_exp  = 5'd0;
    norm_frac = 10'd0;
    if (mant[10]) begin
      norm_exp  = exp;
      norm_frac = mant[9:0];
    end else if (!nz) begin
      norm_exp  = 5'd0;
      norm_frac = 10'd0;
    end else if (exp == 5'd0) begin
      norm_exp  = 5'd0;
      norm_frac = mant[9:0];
    end else if (exp_ext_s > lz_s) begin
      norm_exp  = exp - lz_s[4:0];
      norm_frac = shl_lz_s[9:0];
    end else begin
      norm_exp  = 5'd0;
      norm_frac = shl_sub_s[9:0];
    end
  end

endmodule

// File: rtl/fp16_norm_arbiter.sv
// Round-robin arbiter feeding a two-stage FP16 post-normalization pipeline
// (leading-one search, then shift/exponent adjust) with valid/ready on both sides.
module fp16_norm_arbiter
  import fp16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*FP16_REQ_W-1:0] req_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [FP16_EXP_W-1:0]      out_exp,
  output logic [FP16_FRAC_W-1:0]     out_frac,
  output logic [IDW-1:0]             out_id,
  output logic                       busy
);

  logic         s1_valid_r;
  fp16_unnorm_t s1_data_r;
  logic [IDW-1:0] s1_id_r;
  logic [3:0]   s1_idx_r;
  logic         s1_nz_r;
  logic         s2_valid_r;
  logic [IDW-1:0] rr_ptr_r;

  logic           s2_load_s;
  logic           s1_load_s;
  logic           found_s;
  logic           accept_s;
  logic [IDW-1:0] gnt_idx_s;
  fp16_unnorm_t   gnt_data_s;
  logic [NREQ-1:0] grant_s;
  logic [FP16_EXP_W-1:0]  norm_exp_s;
  logic [FP16_FRAC_W-1:0] norm_frac_s;

  assign s2_load_s = ~s2_valid_r | out_ready;
  assign s1_load_s = ~s1_valid_r | s2_load_s;

  // Pick the first valid requester at or after rr_ptr: upper pass first, then the wrapped pass.
  always_comb begin
    found_s    = 1'b0;
    gnt_idx_s  = '0;
    gnt_data_s = '0;
    grant_s    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid[i] && (IDW'(i) >= rr_ptr_r)) begin
        found_s    = 1'b1;
        gnt_idx_s  = IDW'(i);
        gnt_data_s = req_data[i*FP16_REQ_W +: FP16_REQ_W];
      end else begin
        found_s    = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid[i] && (IDW'(i) < rr_ptr_r)) begin
        found_s    = 1'b1;
        gnt_idx_s  = IDW'(i);
        gnt_data_s = req_data[i*FP16_REQ_W +: FP16_REQ_W];
      end else begin
        found_s    = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant_s[i] = found_s & s1_load_s & (gnt_idx_s == IDW'(i));
    end
  end

  assign req_ready = grant_s;
  assign accept_s  = |(req_valid & grant_s);
  assign out_valid = s2_valid_r;
  assign busy      = s1_valid_r | s2_valid_r;

  // Round-robin pointer moves past the winner of each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= (gnt_idx_s == IDW'(NREQ-1)) ? '0 : gnt_idx_s + IDW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Stage 1: capture the granted operand and its leading-one position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_id_r    <= '0;
      s1_idx_r   <= 4'd0;
      s1_nz_r    <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= accept_s;
      s1_data_r  <= gnt_data_s;
      s1_id_r    <= gnt_idx_s;
      s1_idx_r   <= lead_one_idx(gnt_data_s.mant[9:0]);
      s1_nz_r    <= |gnt_data_s.mant[9:0];
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  fp16_norm_core u_core (
    .exp       (s1_data_r.exp),
    .mant      (s1_data_r.mant),
    .idx       (s1_idx_r),
    .nz        (s1_nz_r),
    .norm_exp  (norm_exp_s),
    .norm_frac (norm_frac_s)
  );

  // Stage 2: registered normalized result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_frac   <= '0;
      out_id     <= '0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sign <= s1_data_r.sign;
        out_exp  <= norm_exp_s;
        out_frac <= norm_frac_s;
        out_id   <= s1_id_r;
      end else begin
        out_sign <= out_sign;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

endmodule

// File: tb/tb_fp16_norm_arbiter.sv
// Directed bench for fp16_norm_arbiter: arbitration order, stalls, normalization cases, reset.
module tb_fp16_norm_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [33:0] req_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [9:0]  out_frac;
  logic [0:0]  out_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  fp16_norm_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [16:0] mk(input logic s, input logic [4:0] e, input logic [10:0] m);
    return {s, e, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One isolated transfer from a single port; result checked two edges later.
  task automatic send_one(input string tag, input int port, input logic [16:0] d,
                          input logic es, input logic [4:0] ee, input logic [9:0] ef);
    logic [1:0] onehot;
    onehot = 2'b00;
    onehot[port] = 1'b1;
    @(negedge clk);
    req_data[port*17 +: 17] = d;
    req_valid = onehot;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = 2'b00;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sign"}, 32'(out_sign), 32'(es));
    chk({tag, "_exp"}, 32'(out_exp), 32'(ee));
    chk({tag, "_frac"}, 32'(out_frac), 32'(ef));
    chk({tag, "_id"}, 32'(out_id), 32'(port));
  endtask

  initial begin
    int acc;
    logic [4:0] held_exp;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_data = 34'd0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", {16'd0, out_sign, out_exp, out_frac}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Alternating grants at full rate.
    req_data[16:0]  = mk(1'b0, 5'd15, 11'h02C);
    req_data[33:17] = mk(1'b1, 5'd20, 11'h5A5);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_id", 32'(out_id), 32'((n - 2) % 2));
        chk("t2_frac", 32'(out_frac), ((n - 2) % 2 == 1) ? 32'h1A5 : 32'h180);
      end
      if (n < 6) begin
        req_valid = 2'b11;
        #1;
        chk("t2_ready", 32'(req_ready), (n % 2 == 0) ? 32'd1 : 32'd2);
      end else begin
        req_valid = 2'b00;
      end
    end
    @(negedge clk);
    chk("t2_drain", 32'(out_valid), 32'd0);

    // Consumer stall: two accepted, then hold.
    acc = 0;
    held_exp = 5'd0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_hold_id", 32'(out_id), 32'd0);
        chk("t3_hold_exp", 32'(out_exp), 32'd10);
      end
      out_ready = 1'b0;
      req_valid = 2'b11;
      #1;
      acc += $countones(req_valid & req_ready);
      if (n >= 2) begin
        chk("t3_stall_ready", 32'(req_ready), 32'd0);
      end
    end
    chk("t3_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    out_ready = 1'b1;
    chk("t3_rel0_id", 32'(out_id), 32'd0);
    chk("t3_rel0_frac", 32'(out_frac), 32'h180);
    @(negedge clk);
    chk("t3_rel1_valid", 32'(out_valid), 32'd1);
    chk("t3_rel1_id", 32'(out_id), 32'd1);
    chk("t3_rel1_val", {16'd0, out_sign, out_exp, out_frac}, {16'd0, 1'b1, 5'd20, 10'h1A5});
    @(negedge clk);
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    send_one("t1", 0, mk(1'b0, 5'd15, 11'h02C), 1'b0, 5'd10, 10'h180);
    send_one("t4_sub", 1, mk(1'b0, 5'd3, 11'h004), 1'b0, 5'd0, 10'h010);
    send_one("t4_e0", 0, mk(1'b0, 5'd0, 11'h004), 1'b0, 5'd0, 10'h004);
    send_one("t4_eqlz", 1, mk(1'b0, 5'd8, 11'h004), 1'b0, 5'd0, 10'h200);
    send_one("t4_gtlz", 0, mk(1'b0, 5'd9, 11'h004), 1'b0, 5'd1, 10'h000);
    send_one("t5_zero", 1, mk(1'b1, 5'd7, 11'h000), 1'b1, 5'd0, 10'h000);
    send_one("t5_norm", 0, mk(1'b0, 5'd20, 11'h5A5), 1'b0, 5'd20, 10'h1A5);
    send_one("t5_lsb", 0, mk(1'b0, 5'd15, 11'h001), 1'b0, 5'd5, 10'h000);

    // Fill both stages, then reset mid-flight.
    @(negedge clk);
    out_ready = 1'b0;
    req_data[16:0]  = mk(1'b0, 5'd3, 11'h004);
    req_data[33:17] = mk(1'b1, 5'd20, 11'h5A5);
    req_valid = 2'b11;
    #1;
    chk("t6_pre_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("t6_full_busy", 32'(busy), 32'd1);
    chk("t6_full_valid", 32'(out_valid), 32'd1);
    chk("t6_full_id", 32'(out_id), 32'd1);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_outs", {16'd0, out_sign, out_exp, out_frac}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_no_stale", 32'(out_valid), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    req_data[16:0] = mk(1'b0, 5'd15, 11'h02C);
    req_valid = 2'b11;
    #1;
    chk("t6_tie_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_id", 32'(out_id), 32'd0);
    chk("t6_out_exp", 32'(out_exp), 32'd10);
    @(negedge clk);
    chk("t6_end", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
